// File: rtl/dac_spi_pkg.sv
// Shared types and defaults for the DAC SPI transmitter.
// DAC_SPI_LDAC_EN is undefined by default: no ldac_n strobe, DAC updates on cs_n rising.
package dac_spi_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_CLK_DIV = 4;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP,
        LOAD
    } state_t;

endpackage

// File: rtl/spi_tick_gen.sv
// Phase timer: one-cycle tick every CLK_DIV enabled cycles, cleared while disabled.
module spi_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = enable && (cnt == LAST);

    // Every phase is exactly CLK_DIV cycles, so wrapping on tick restarts each phase at 0.
    always_ff @(posedge clk) begin
        if (rst || !enable) cnt <= '0;
        else if (tick)      cnt <= '0;
        else                cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/dac_spi_tx.sv
// MSB-first SPI serialiser for the potential-control DAC (mode 0, registered pins).
// Define DAC_SPI_LDAC_EN to add the ldac_n port and a LOAD phase after GAP.
module dac_spi_tx
    import dac_spi_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             cs_n,
    output logic             sclk,
    output logic             mosi,
    output logic             busy,
    output logic             done
`ifdef DAC_SPI_LDAC_EN
    ,
    output logic             ldac_n
`endif
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
`ifdef DAC_SPI_LDAC_EN
    localparam state_t DONE_ST = LOAD;
`else
    localparam state_t DONE_ST = GAP;
`endif

    state_t           state, state_next;
    logic [WIDTH-1:0] sreg;
    logic [BW-1:0]    bit_cnt;
    logic             hi, first, tick, accept, framed;

    assign accept = din_valid && din_ready;
    assign busy   = ~din_ready;
    assign framed = (state == SETUP) || (state == SHIFT) || (state == HOLD);

    spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .enable (state != IDLE),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            first <= 1'b1;
        end else begin
            state <= state_next;
            first <= (state_next != state);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (accept) state_next = SETUP;
            SETUP: if (tick) state_next = SHIFT;
            SHIFT: if (tick && hi && bit_cnt == LAST_BIT) state_next = HOLD;
            HOLD:  if (tick) state_next = GAP;
`ifdef DAC_SPI_LDAC_EN
            GAP:   if (tick) state_next = LOAD;
            LOAD:  if (tick) state_next = IDLE;
`else
            GAP:   if (tick) state_next = IDLE;
`endif
            default: state_next = IDLE;
        endcase
    end

    // The last bit is never shifted out, so HOLD keeps the LSB on mosi.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg    <= '0;
            bit_cnt <= '0;
            hi      <= 1'b0;
        end else if (accept) begin
            sreg    <= din;
            bit_cnt <= '0;
            hi      <= 1'b0;
        end else if (state == SHIFT && tick) begin
            hi <= !hi;
            if (hi && bit_cnt != LAST_BIT) begin
                bit_cnt <= bit_cnt + BW'(1);
                sreg    <= {sreg[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Pins follow the state one cycle later, which puts cs_n low at accept+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_n      <= 1'b1;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
            done      <= 1'b0;
            din_ready <= 1'b1;
        end else begin
            cs_n      <= !framed;
            sclk      <= (state == SHIFT) && hi;
            mosi      <= framed && sreg[WIDTH-1];
            done      <= (state == DONE_ST) && first;
            din_ready <= (state == IDLE) && !accept;
        end
    end

`ifdef DAC_SPI_LDAC_EN
    always_ff @(posedge clk) begin
        if (rst) ldac_n <= 1'b1;
        else     ldac_n <= (state != LOAD);
    end
`endif

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: default instance (16 bits, /4) plus a minimum instance (2 bits, /1).
module tb_dac_spi_tx;

`ifdef DAC_SPI_LDAC_EN
    localparam int RDY_EDGE  = 145;
    localparam int DONE_EDGE = 141;
    localparam int MIN_RDY   = 9;
    localparam int B2B_RDY2  = 291;
`else
    localparam int RDY_EDGE  = 141;
    localparam int DONE_EDGE = 137;
    localparam int MIN_RDY   = 8;
    localparam int B2B_RDY2  = 283;
`endif

    logic        clk, rst;
    logic [15:0] din;
    logic        din_valid, din_ready, cs_n, sclk, mosi, busy, done;
    logic [1:0]  m_din;
    logic        m_valid, m_ready, m_cs_n, m_sclk, m_mosi, m_busy, m_done;
`ifdef DAC_SPI_LDAC_EN
    logic        ldac_n, m_ldac_n;
`endif

    int errors = 0;
    int checks = 0;

    dac_spi_tx #(.WIDTH(16), .CLK_DIV(4)) u_dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .busy(busy), .done(done)
`ifdef DAC_SPI_LDAC_EN
        , .ldac_n(ldac_n)
`endif
    );

    dac_spi_tx #(.WIDTH(2), .CLK_DIV(1)) u_min (
        .clk(clk), .rst(rst), .din(m_din), .din_valid(m_valid), .din_ready(m_ready),
        .cs_n(m_cs_n), .sclk(m_sclk), .mosi(m_mosi), .busy(m_busy), .done(m_done)
`ifdef DAC_SPI_LDAC_EN
        , .ldac_n(m_ldac_n)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One frame on the default instance; edges are counted from the accept edge (edge 0).
    task automatic frame(input logic [15:0] d, input bit toggle,
                         output logic [15:0] word, output int rises, output int cslow,
                         output int dones, output int done_edge, output int cs_rise,
                         output int rdy_edge, output int ldac_low, output int ldac_first);
        logic prev_sclk, prev_cs;
        int   w;
        word = '0; rises = 0; cslow = 0; dones = 0; done_edge = 0;
        cs_rise = 0; rdy_edge = 0; ldac_low = 0; ldac_first = 0;
        w = 0;
        while (!din_ready && w < 20) begin tick; w++; end
        din = d; din_valid = 1'b1;
        tick;
        din_valid = 1'b0;
        prev_sclk = sclk; prev_cs = cs_n;
        for (int k = 1; k <= 200; k++) begin
            if (toggle && k >= 20 && k < 60) begin
                din_valid = k[0];
                din = ~d;
            end else if (toggle && k == 60) begin
                din_valid = 1'b0;
                din = d;
            end
            tick;
            if (sclk && !prev_sclk) begin word = {word[14:0], mosi}; rises++; end
            if (!cs_n) cslow++;
            if (cs_n && !prev_cs) cs_rise = k;
            if (done) begin dones++; done_edge = k; end
`ifdef DAC_SPI_LDAC_EN
            if (!ldac_n) begin
                if (ldac_low == 0) ldac_first = k;
                ldac_low++;
            end
`endif
            prev_sclk = sclk; prev_cs = cs_n;
            if (din_ready) begin rdy_edge = k; break; end
        end
    endtask

    typedef struct {
        logic [15:0] din;
        logic [15:0] exp_word;
        bit          toggle;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [15:0] word, w1, w2;
        int rises, cslow, dones, done_edge, cs_rise, rdy_edge, ldac_low, ldac_first;
        int rdy_first, rdy_cnt, rdy_second, cs_fall2;
        int r1, r2, mrdy;
        logic [1:0] mbits;
        logic prev_sclk, prev_cs;

        vecs[0] = '{16'hA5C3, 16'b1010_0101_1100_0011, 1'b0};
        vecs[1] = '{16'h0000, 16'b0000_0000_0000_0000, 1'b0};
        vecs[2] = '{16'h7FFE, 16'b0111_1111_1111_1110, 1'b0};
        vecs[3] = '{16'h8001, 16'b1000_0000_0000_0001, 1'b1};

        rst = 1'b1; din = '0; din_valid = 1'b0; m_din = '0; m_valid = 1'b0;
        repeat (3) tick;
        rst = 1'b0;
        tick;
        chk("reset cs_n", cs_n, 1);
        chk("reset sclk", sclk, 0);
        chk("reset mosi", mosi, 0);
        chk("reset done", done, 0);
        chk("reset busy", busy, 0);
        chk("reset din_ready", din_ready, 1);
`ifdef DAC_SPI_LDAC_EN
        chk("reset ldac_n", ldac_n, 1);
`endif

        foreach (vecs[i]) begin
            frame(vecs[i].din, vecs[i].toggle, word, rises, cslow, dones, done_edge,
                  cs_rise, rdy_edge, ldac_low, ldac_first);
            chk($sformatf("v%0d word", i), word, vecs[i].exp_word);
            chk($sformatf("v%0d rises", i), rises, 16);
            chk($sformatf("v%0d cs_low", i), cslow, 136);
            chk($sformatf("v%0d cs_rise", i), cs_rise, 137);
            chk($sformatf("v%0d dones", i), dones, 1);
            chk($sformatf("v%0d done_edge", i), done_edge, DONE_EDGE);
            chk($sformatf("v%0d ready_edge", i), rdy_edge, RDY_EDGE);
`ifdef DAC_SPI_LDAC_EN
            chk($sformatf("v%0d ldac_low", i), ldac_low, 4);
            chk($sformatf("v%0d ldac_first", i), ldac_first, 141);
`endif
        end

        // Back-to-back with din_valid held high.
        din = 16'h0001; din_valid = 1'b1;
        tick;
        din = 16'hFFFF;
        w1 = '0; w2 = '0; rises = 0; rdy_first = 0; rdy_cnt = 0; rdy_second = 0; cs_fall2 = 0;
        prev_sclk = sclk; prev_cs = cs_n;
        for (int k = 1; k <= 400; k++) begin
            tick;
            if (sclk && !prev_sclk) begin
                if (rises < 16) w1 = {w1[14:0], mosi};
                else            w2 = {w2[14:0], mosi};
                rises++;
            end
            if (!cs_n && prev_cs && k > 2) cs_fall2 = k;
            prev_sclk = sclk; prev_cs = cs_n;
            if (din_ready && k <= 200) begin
                if (rdy_first == 0) rdy_first = k;
                rdy_cnt++;
            end
            if (k == RDY_EDGE + 1) din_valid = 1'b0;
            if (din_ready && k > 200) begin rdy_second = k; break; end
        end
        chk("b2b word1", w1, 16'h0001);
        chk("b2b word2", w2, 16'hFFFF);
        chk("b2b rises", rises, 32);
        chk("b2b first ready", rdy_first, RDY_EDGE);
        chk("b2b idle cycles", rdy_cnt, 1);
        chk("b2b cs fall2", cs_fall2, RDY_EDGE + 2);
        chk("b2b second ready", rdy_second, B2B_RDY2);

        // Reset in the middle of SHIFT.
        din = 16'hA5C3; din_valid = 1'b1;
        tick;
        din_valid = 1'b0;
        dones = 0;
        for (int k = 1; k <= 49; k++) begin
            tick;
            if (done) dones++;
        end
        chk("midshift cs_n", cs_n, 0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        if (done) dones++;
        chk("rst cs_n", cs_n, 1);
        chk("rst sclk", sclk, 0);
        chk("rst mosi", mosi, 0);
        chk("rst busy", busy, 0);
        chk("rst din_ready", din_ready, 1);
        chk("rst no done", dones, 0);
        frame(16'h3C5A, 1'b0, word, rises, cslow, dones, done_edge,
              cs_rise, rdy_edge, ldac_low, ldac_first);
        chk("after rst word", word, 16'b0011_1100_0101_1010);
        chk("after rst dones", dones, 1);
        chk("after rst ready_edge", rdy_edge, RDY_EDGE);

        // Minimum divider instance.
        m_din = 2'b10; m_valid = 1'b1;
        tick;
        m_valid = 1'b0;
        r1 = 0; r2 = 0; mrdy = 0; mbits = '0; rises = 0;
        prev_sclk = m_sclk;
        for (int k = 1; k <= 20; k++) begin
            tick;
            if (m_sclk && !prev_sclk) begin
                mbits = {mbits[0], m_mosi};
                if (rises == 0) r1 = k; else r2 = k;
                rises++;
            end
            prev_sclk = m_sclk;
            if (m_ready) begin mrdy = k; break; end
        end
        chk("min rises", rises, 2);
        chk("min bits", mbits, 2'b10);
        chk("min first rise", r1, 3);
        chk("min sclk period", r2 - r1, 2);
        chk("min ready_edge", mrdy, MIN_RDY);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
